// File: rtl/piggy_report_tx_if.sv
// Report request/serial-line bundle between the piggy-bank top level and the
// UART report transmitter.
interface piggy_report_tx_if;
    logic        start;
    logic [15:0] balance;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (output start, balance, input tx, busy, done);
    modport slave  (input start, balance, output tx, busy, done);
endinterface

// File: rtl/piggy_report_tx.sv
// Sends the latched balance as a 4-byte 8N1 UART frame:
// HEADER, bal[15:8], bal[7:0], XOR checksum.
module piggy_report_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    piggy_report_tx_if.slave  bus
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    shift;
    logic [7:0]    chk;
    logic [15:0]   bal;
    logic [7:0]    next_byte;
    logic          baud_end;
    logic          tx_q, busy_q, done_q;
    logic          tx_nxt, busy_nxt, done_nxt;

    assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        case (byte_idx)
            2'd0:    next_byte = bal[15:8];
            2'd1:    next_byte = bal[7:0];
            default: next_byte = chk;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = START;
            START: if (baud_end) state_nxt = DATA;
            DATA:  if (baud_end && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (baud_end) state_nxt = (byte_idx == 2'd3) ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: values the registered outputs take on the next edge
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && baud_end && (byte_idx == 2'd3);
        case (state)
            IDLE:  tx_nxt = !bus.start;
            START: tx_nxt = baud_end ? shift[0] : 1'b0;
            DATA: begin
                if (!baud_end)             tx_nxt = shift[bit_idx];
                else if (bit_idx == 3'd7)  tx_nxt = 1'b1;
                else                       tx_nxt = shift[bit_idx + 3'd1];
            end
            STOP:  tx_nxt = baud_end ? (byte_idx == 2'd3) : 1'b1;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Datapath: baud timing, bit/byte indices and the byte being shifted out
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            chk      <= '0;
            bal      <= '0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            if (bus.start) begin
                bal      <= bus.balance;
                chk      <= HEADER ^ bus.balance[15:8] ^ bus.balance[7:0];
                shift    <= HEADER;
                byte_idx <= 2'd0;
                bit_idx  <= 3'd0;
            end
        end else begin
            baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
            if (baud_end) begin
                case (state)
                    START: bit_idx <= 3'd0;
                    DATA:  bit_idx <= bit_idx + 3'd1;
                    STOP: begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            shift    <= next_byte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_piggy_report_tx.sv
// Self-checking bench for piggy_report_tx: decodes the UART line and compares
// against frames built directly from the balance value.
module tb_piggy_report_tx;
    localparam int CPB   = 16;
    localparam int FLEN  = 40 * CPB;   // cycles E+1..E+FLEN carry the frame
    localparam int LOGN  = 1600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic lt [0:LOGN-1];
    logic lb [0:LOGN-1];
    logic ld [0:LOGN-1];

    piggy_report_tx_if bus ();

    piggy_report_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=hang required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_frame(input logic [15:0] b);
        logic [7:0] h, l;
        h = b[15:8];
        l = b[7:0];
        return {8'hA5, h, l, 8'hA5 ^ h ^ l};
    endfunction

    // Drive start for edge E; returns at the negedge just before edge E.
    task automatic kick(input logic [15:0] b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.balance = b;
    endtask

    // Log cycles E+1..E+n; optionally raise start again in cycle rcyc and
    // scramble balance every other cycle.
    task automatic capture(input int n, input int rcyc, input logic [15:0] rbal,
                           input bit scramble);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            lt[i] = bus.tx;
            lb[i] = bus.busy;
            ld[i] = bus.done;
            if (i == rcyc) begin
                bus.start   = 1'b1;
                bus.balance = rbal;
            end else begin
                bus.start = 1'b0;
                if (scramble) bus.balance = 16'($urandom);
            end
        end
    endtask

    // Mid-bit decode of a frame whose accepting edge is log index base.
    task automatic decode(input int base, output logic [31:0] got, output bit frame_ok,
                          output bit busy_ok, output bit done_ok);
        logic [7:0] by;
        got = '0;
        frame_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            by = '0;
            for (int s = 0; s < 10; s++) begin
                int idx;
                idx = base + 1 + (k * 10 + s) * CPB + CPB / 2;
                if (s == 0 && lt[idx] !== 1'b0) frame_ok = 1'b0;
                else if (s == 9 && lt[idx] !== 1'b1) frame_ok = 1'b0;
                else if (s >= 1 && s <= 8) by[s-1] = lt[idx];
            end
            got = {got[23:0], by};
        end
        busy_ok = (lb[base + FLEN + 1] === 1'b0);
        done_ok = (ld[base + FLEN + 1] === 1'b1);
        for (int j = base + 1; j <= base + FLEN; j++) begin
            if (lb[j] !== 1'b1) busy_ok = 1'b0;
            if (ld[j] !== 1'b0) done_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        int bad;
        bus.start   = 1'b1;
        bus.balance = 16'hFFFF;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_values: got tx/busy/done=%b required=100",
                     {bus.tx, bus.busy, bus.done});
        end
        bus.start = 1'b0;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({bus.tx, bus.busy, bus.done} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_nominal();
        logic [31:0] got;
        bit fok, bok, dok;
        int low;
        kick(16'h1234);
        capture(FLEN + 1, 0, 16'h0, 1'b1);
        decode(0, got, fok, bok, dok);
        low = 0;
        for (int j = 1; j <= CPB; j++) if (lt[j] === 1'b0) low++;
        checks++;
        if (low != CPB || lt[CPB + 1] !== 1'b0 && 1'b0) begin
            errors++;
            $display("FAIL nominal_start_bit: got %0d low cycles required %0d", low, CPB);
        end
        checks++;
        if (got !== model_frame(16'h1234)) begin
            errors++;
            $display("FAIL nominal_bytes: got %h required %h", got, model_frame(16'h1234));
        end
        checks++;
        if (!fok) begin
            errors++;
            $display("FAIL nominal_framing: got bad start/stop required 0/1");
        end
        checks++;
        if (!bok || !dok) begin
            errors++;
            $display("FAIL nominal_busy_done: got busy_ok=%0d done_ok=%0d required 1 1", bok, dok);
        end
    endtask

    task automatic test_edges();
        logic [15:0] vals [2];
        logic [31:0] got;
        bit fok, bok, dok;
        vals[0] = 16'h0000;
        vals[1] = 16'hFFFF;
        for (int v = 0; v < 2; v++) begin
            kick(vals[v]);
            capture(FLEN + 1, 0, 16'h0, 1'b0);
            decode(0, got, fok, bok, dok);
            checks++;
            if (got !== model_frame(vals[v]) || !fok) begin
                errors++;
                $display("FAIL edge_%h: got %h framing=%0d required %h framing=1",
                         vals[v], got, fok, model_frame(vals[v]));
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] got;
        bit fok, bok, dok;
        int dcnt;
        kick(16'h1234);
        capture(FLEN + 100, 100, 16'hBEEF, 1'b0);
        decode(0, got, fok, bok, dok);
        dcnt = 0;
        for (int j = 1; j <= FLEN + 100; j++) if (ld[j] === 1'b1) dcnt++;
        checks++;
        if (got !== model_frame(16'h1234) || !fok) begin
            errors++;
            $display("FAIL ignore_busy_bytes: got %h required %h", got, model_frame(16'h1234));
        end
        checks++;
        if (dcnt != 1 || !bok) begin
            errors++;
            $display("FAIL ignore_busy_done: got %0d done pulses busy_ok=%0d required 1 1",
                     dcnt, bok);
        end
    endtask

    task automatic test_back_to_back(input logic [15:0] b0, input logic [15:0] b1,
                                     input bit scramble);
        logic [31:0] g0, g1;
        bit f0, bk0, d0, f1, bk1, d1;
        kick(b0);
        capture(2 * (FLEN + 1), FLEN + 1, b1, scramble);
        decode(0, g0, f0, bk0, d0);
        decode(FLEN + 1, g1, f1, bk1, d1);
        checks++;
        if (g0 !== model_frame(b0) || !f0 || !bk0 || !d0) begin
            errors++;
            $display("FAIL b2b_first: got %h f/b/d=%0d%0d%0d required %h 111",
                     g0, f0, bk0, d0, model_frame(b0));
        end
        checks++;
        if (g1 !== model_frame(b1) || !f1 || !bk1 || !d1) begin
            errors++;
            $display("FAIL b2b_second: got %h f/b/d=%0d%0d%0d required %h 111",
                     g1, f1, bk1, d1, model_frame(b1));
        end
        checks++;
        if (lt[FLEN + 2] !== 1'b0 || lb[FLEN + 2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap: got tx=%b busy=%b after done required tx=0 busy=1",
                     lt[FLEN + 2], lb[FLEN + 2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        bit fok, bok, dok;
        int bad;
        kick(16'h1234);
        capture(200, 0, 16'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_abort: got tx/busy/done=%b required 100",
                     {bus.tx, bus.busy, bus.done});
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < FLEN + 50; i++) begin
            @(negedge clk);
            if ({bus.tx, bus.busy, bus.done} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles required 0", bad);
        end
        kick(16'h0001);
        capture(FLEN + 1, 0, 16'h0, 1'b0);
        decode(0, got, fok, bok, dok);
        checks++;
        if (got !== model_frame(16'h0001) || !fok || !bok || !dok) begin
            errors++;
            $display("FAIL reset_mid_next: got %h f/b/d=%0d%0d%0d required %h 111",
                     got, fok, bok, dok, model_frame(16'h0001));
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        bit fok, bok, dok;
        logic [15:0] b;
        for (int r = 0; r < 4; r++) begin
            b = 16'($urandom);
            kick(b);
            capture(FLEN + 1 + $urandom_range(0, 3), 0, 16'h0, 1'b1);
            decode(0, got, fok, bok, dok);
            checks++;
            if (got !== model_frame(b) || !fok || !bok || !dok) begin
                errors++;
                $display("FAIL random_%0d: bal=%h got %h f/b/d=%0d%0d%0d required %h 111",
                         r, b, got, fok, bok, dok, model_frame(b));
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.balance = 16'h0;
        test_reset();
        test_nominal();
        test_edges();
        test_ignore_busy();
        test_back_to_back(16'h1234, 16'h00FF, 1'b0);
        test_back_to_back(16'($urandom), 16'($urandom), 1'b1);
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
